// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryption core, one cipher round per clock.
// Round keys are expanded on the fly from a sliding window of the last Nk
// key-schedule words. Optional feature: define AES_BLOCK_COUNT_EN to add the
// blk_count output counting completed output handshakes.
module aes_iter_core #(
   parameter int Nk = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [127:0]      dataIn,
   input  logic [Nk*32-1:0]  keyIn,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [127:0]      dataOut,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef AES_BLOCK_COUNT_EN
   output logic              busy,
   output logic [31:0]       blk_count
`else
   output logic              busy
`endif
);

   localparam int Nr = Nk + 6;
   localparam logic [3:0] NR_L = 4'(Nr);

   generate
      if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
         $error("aes_iter_core: Nk must be 4, 6 or 8");
      end
   endgenerate

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   // Key window: element 0 is the oldest word; its low four words are the
   // round key of the round being computed.
   typedef logic [Nk-1:0][31:0] win_t;

   state_t        state_q, state_d;
   logic [3:0]    round_q, round_d;
   logic [127:0]  cipher_q, cipher_d;
   win_t          key_win_q, key_win_d;
   logic [127:0]  data_out_q, data_out_d;
   logic          out_valid_q, out_valid_d;
   win_t          key_words;
   logic [127:0]  round_result;
`ifdef AES_BLOCK_COUNT_EN
   logic [31:0]   blk_count_q, blk_count_d;
`endif

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input int j);
      case (j)
         1:       return 8'h01;
         2:       return 8'h02;
         3:       return 8'h04;
         4:       return 8'h08;
         5:       return 8'h10;
         6:       return 8'h20;
         7:       return 8'h40;
         8:       return 8'h80;
         9:       return 8'h1b;
         10:      return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s,
                                              input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [127:0] sr, mc;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[127 - 8*(4*c + r) -: 8] = b[4*((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
      return (last ? sr : mc) ^ rk;
   endfunction

   // Slides the window forward by four words; i0 is the schedule index of
   // the first new word.
   function automatic win_t next_window(input win_t win, input int i0);
      win_t        res;
      logic [31:0] prev, t;
      res  = '0;
      prev = win[Nk-1];
      for (int j = 0; j < Nk - 4; j++) res[j] = win[j + 4];
      for (int k = 0; k < 4; k++) begin
         if ((i0 + k) % Nk == 0)
            t = sub_word(rot_word(prev)) ^ {rcon((i0 + k) / Nk), 24'h0};
         else if (Nk == 8 && (i0 + k) % 8 == 4)
            t = sub_word(prev);
         else
            t = prev;
         prev = win[k] ^ t;
         res[Nk - 4 + k] = prev;
      end
      return res;
   endfunction

   // Split the cipher key into schedule words, w[0] being the top word.
   always_comb begin
      key_words = '0;
      for (int j = 0; j < Nk; j++) key_words[j] = keyIn[32*(Nk-1-j) +: 32];
   end

   // Next-state logic for the IDLE/ROUND/DONE sequencer and its datapath.
   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      cipher_d     = cipher_q;
      key_win_d    = key_win_q;
      data_out_d   = data_out_q;
      out_valid_d  = out_valid_q;
      round_result = aes_round(cipher_q,
                               {key_win_q[0], key_win_q[1], key_win_q[2], key_win_q[3]},
                               round_q == NR_L);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               cipher_d  = dataIn ^ {key_words[0], key_words[1], key_words[2], key_words[3]};
               key_win_d = next_window(key_words, Nk);
               round_d   = 4'd1;
               state_d   = ROUND;
            end
         end
         ROUND: begin
            if (round_q == NR_L) begin
               data_out_d  = round_result;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cipher_d  = round_result;
               key_win_d = next_window(key_win_q, 4*int'(round_q) + Nk);
               round_d   = round_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any block in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         round_q     <= '0;
         cipher_q    <= '0;
         key_win_q   <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         cipher_q    <= cipher_d;
         key_win_q   <= key_win_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef AES_BLOCK_COUNT_EN
   // Count completed output handshakes, wrapping naturally at 32 bits.
   always_comb begin
      blk_count_d = blk_count_q;
      if (out_valid_q && out_ready) blk_count_d = blk_count_q + 32'd1;
   end

   // Handshake counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blk_count_q <= '0;
      else        blk_count_q <= blk_count_d;
   end

   assign blk_count = blk_count_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == ROUND);
   assign dataOut   = data_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words; legal values 4, 6 and 8.
REQ-002 SHALL have local parameter Nr, equal to Nk+6, the round count; block width is fixed at 128 bits (Nb=4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dataIn, input, 128 bits: plaintext block; dataIn[127:120] is byte 0.
REQ-006 SHALL have port keyIn, input, Nk*32 bits: cipher key; the top byte is key byte 0.
REQ-007 SHALL have port in_valid, input, 1 bit: the block and key at the inputs are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the core can accept a block.
REQ-009 SHALL have port dataOut, output, 128 bits: ciphertext block, same byte order as dataIn.
REQ-010 SHALL have port out_valid, output, 1 bit: dataOut holds a completed ciphertext.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes dataOut.
REQ-012 SHALL have port busy, output, 1 bit: high in the ROUND state.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ROUND, DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL accept a block on an edge where in_valid && in_ready; at that edge it SHALL capture keyIn, load state = dataIn ^ w[0..3], set round counter = 1 and enter ROUND.
REQ-016 SHALL ignore dataIn and keyIn at every edge other than the accept edge.
REQ-017 In ROUND, SHALL perform exactly one AES round per cycle: SubBytes, ShiftRows, MixColumns, then AddRoundKey with w[4r..4r+3].
REQ-018 SHALL generate round keys on the fly, 4 key words per cycle, equal to the FIPS-197 schedule for the configured Nk; RotWord/SubWord and Rcon SHALL apply at i mod Nk == 0, and SubWord alone at i mod 8 == 4 when Nk=8.
REQ-019 SHALL omit MixColumns when round counter == Nr, then load dataOut, raise out_valid and enter DONE.
REQ-020 SHALL raise out_valid exactly Nr cycles after the accept edge.
REQ-021 In DONE, SHALL hold dataOut and out_valid stable until out_ready is sampled high; at that edge it SHALL clear out_valid and return to IDLE.
REQ-022 SHALL keep the dataOut value after the handshake until the next completion overwrites it.
REQ-023 SHALL make the minimum issue interval Nr+2 cycles; in_valid asserted while in ROUND or DONE SHALL have no effect and SHALL not be queued.
REQ-024 SHALL keep the round counter in the range 1..Nr and SHALL not wrap it in any state.
REQ-025 SHALL reject an illegal Nk at elaboration and SHALL not silently default it.

Reset
REQ-026 SHALL, while rst_n is low, immediately force: FSM = IDLE, out_valid = 0, busy = 0, dataOut = 0, round counter = 0, and all state/key registers = 0.
REQ-027 SHALL, on reset asserted mid-ROUND or mid-DONE, abandon the block without emitting any output.
REQ-028 SHALL have in_ready = 1 on the first edge after rst_n is released.

Configuration
REQ-029 SHALL, with macro AES_BLOCK_COUNT_EN defined, add output blk_count[31:0], which increments on each out_valid && out_ready edge, wraps 0xFFFFFFFF -> 0, and resets to 0.
REQ-030 SHALL, without AES_BLOCK_COUNT_EN, have no blk_count port and no counter logic, with all other behaviour identical.

Verification
REQ-031 Nk=4, key 000102..0f, pt 00112233..ff -> dataOut 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
REQ-032 Nk=6, key 00..17, same pt -> dataOut dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles; Nk=8, key 00..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-033 Hold out_ready low for 20 cycles after completion -> out_valid and dataOut stable, in_ready 0 throughout; out_ready high -> IDLE next cycle.
REQ-034 Toggle in_valid, dataIn and keyIn during ROUND -> result unchanged from REQ-031, no second block accepted.
REQ-035 Assert rst_n low at round 5 -> out_valid 0, dataOut 0 immediately; after release a new REQ-031 block completes correctly.
REQ-036 With AES_BLOCK_COUNT_EN, three back-to-back blocks -> blk_count 3; force the counter to 0xFFFFFFFF, complete one block -> blk_count 0.
